enc83_irq: RTL
==============

Name: enc83_irq

Overview:
- Registered 8-to-3 priority encoder with request latching and a valid/ack handshake.
- Inverse of the 3-to-8 gated decoders in the Tom/Jerry netlists: it collapses eight request lines into a 3-bit code plus a valid strobe.
- Sits between per-source request lines (timers, blitter, video, DSP) and the CPU-side interrupt/vector logic.

Parameters:
- PRIO_HIGH, 1, 1 = index 7 is highest priority; 0 = index 0 is highest priority.

Ports:
- sys_clk  input  1  system clock; all state changes on the rising edge.
- resetl  input  1  asynchronous reset, active low.
- rq  input  8  request lines, active high; rq[i] is source i.
- mask  input  8  per-source enable; a request with mask[i]=0 is never latched.
- gl  input  1  active-low present enable; when high, no new code is presented.
- ack  input  1  consumer acknowledge, sampled only while valid=1.
- z  output  3  encoded index of the presented source.
- valid  output  1  z holds a presented, unacknowledged source.
- pend  output  8  pending register, for status readback.

Behaviour:
- Reset (resetl low, asynchronous): pend=0, z=0, valid=0, FSM=IDLE. Deassertion is taken synchronously to sys_clk by the surrounding logic.
- Latching: on each edge, pend[i] <= (pend[i] & ~clr[i]) | (rq[i] & mask[i]).
  - clr is one-hot on z and active only on an ack edge (see ACK below).
  - Set wins over clear: a source still requesting during its own ack stays pending.
- Masking: clearing mask[i] does not drop an already-pending bit. It only blocks new sets.
- Priority: sel = highest-priority set bit of pend, as selected by PRIO_HIGH. Combinational and internal only.
- FSM states: IDLE, PRESENT, GAP.
  - IDLE: if pend!=0 and gl=0, then z<=sel, valid<=1, go to PRESENT. Otherwise hold z and keep valid=0.
  - PRESENT: z and valid hold stable regardless of rq, mask, gl, or a newly arriving higher-priority request (no pre-emption). If ack=1, then clr[z]=1, valid<=0, go to GAP.
  - GAP: one dead cycle with valid=0, then go to IDLE. This guarantees valid is low for at least one full cycle between codes.
- Latency:
  - rq sampled high at edge E0 sets pend at E0.
  - valid=1 and z are visible after E1 (2 edges from request).
  - After ack at edge Ea, the earliest next valid is after Ea+2.
- gl rising while in PRESENT has no effect; the handshake must complete.
- ack in IDLE or GAP is ignored.
- pend == 0 in IDLE: valid stays 0 and z keeps its last value.

Optional Feature:
- Macro: ENC83_EDGE_EN.
- Defined: requests are rising-edge triggered.
  - Adds an 8-bit rq_d register (reset 0); the set term becomes rq & ~rq_d & mask.
  - A held-high request pends once per rising edge.
  - A rising edge coinciding with an ack on the same bit re-pends it (set wins).
- Undefined: level-sensitive as described in Behaviour. rq_d does not exist.

Test Plan:
- Reset mid-PRESENT: valid=1, z=5, pend=0x20; pull resetl low -> pend=0x00, valid=0, z=0 immediately, without waiting for a clock edge.
- Priority, PRIO_HIGH=1: pulse rq=0x12 for one cycle, mask=0xFF, gl=0 -> valid after 2 edges with z=4. Ack -> z=1 presented 2 edges after the ack. Ack -> valid stays 0, pend=0x00.
- No pre-emption: z=1 presented; raise rq[7] -> z stays 1 until ack. z=7 appears after GAP.
- Mask and gl:
  - mask=0x7F, rq[7]=1 -> pend stays 0x00, valid=0.
  - mask=0xFF, gl=1 -> pend=0x80, valid=0.
  - gl=0 -> z=7 valid on the next edge.
- Set-wins on ack, level mode: rq[3] held high, ack z=3 -> pend[3] stays 1, valid drops for the GAP cycle, z=3 re-presented at Ea+2.
- ENC83_EDGE_EN defined: rq[2] held high for 10 cycles -> exactly one presentation of z=2. After ack, valid stays 0 until rq[2] falls and rises again.

Source files
------------

// File: rtl/enc83_irq.sv
// enc83_irq: registered 8-to-3 priority encoder with request latching and a
// valid/ack handshake. Requests are latched into pend, the highest-priority
// pending source is presented on z/valid and held until acknowledged, then a
// one-cycle gap separates it from the next code.
// Optional feature macro: ENC83_EDGE_EN (rising-edge triggered requests).
module enc83_irq #(
  parameter bit PRIO_HIGH = 1'b1  // 1: index 7 wins, 0: index 0 wins
) (
  input  logic       sys_clk,
  input  logic       resetl,
  input  logic [7:0] rq,
  input  logic [7:0] mask,
  input  logic       gl,
  input  logic       ack,
  output logic [2:0] z,
  output logic       valid,
  output logic [7:0] pend
);

  localparam logic [1:0] S_IDLE    = 2'd0;
  localparam logic [1:0] S_PRESENT = 2'd1;
  localparam logic [1:0] S_GAP     = 2'd2;

  logic [1:0] state_q, state_d;
  logic [2:0] z_q, z_d;
  logic       valid_q, valid_d;
  logic [7:0] pend_q, pend_d;
  logic [7:0] set_w, clr_w;
  logic [2:0] sel;

`ifdef ENC83_EDGE_EN
  // Previous request sample, so a held-high line pends only on its rising edge.
  logic [7:0] rq_prev_q;

  // Track last cycle's request lines.
  always_ff @(posedge sys_clk or negedge resetl) begin
    if (!resetl) rq_prev_q <= 8'h00;
    else         rq_prev_q <= rq;
  end

  assign set_w = rq & ~rq_prev_q & mask;
`else
  assign set_w = rq & mask;
`endif

  // Clear only the presented source, and only on the acknowledging edge.
  assign clr_w = (state_q == S_PRESENT && ack) ? (8'h01 << z_q) : 8'h00;

  // Set wins over clear so a source still requesting during its ack re-pends.
  assign pend_d = (pend_q & ~clr_w) | set_w;

  // Priority select over pend: the last hit in scan order is the winner.
  always_comb begin
    logic [2:0] k;
    sel = 3'd0;
    for (int i = 0; i < 8; i++) begin
      k = PRIO_HIGH ? 3'(i) : 3'(7 - i);
      if (pend_q[k]) sel = k;
    end
  end

  // Handshake FSM: present once, hold until ack, then one dead cycle.
  always_comb begin
    state_d = state_q;
    z_d     = z_q;
    valid_d = valid_q;
    case (state_q)
      S_IDLE: begin
        valid_d = 1'b0;
        if (pend_q != 8'h00 && !gl) begin
          z_d     = sel;
          valid_d = 1'b1;
          state_d = S_PRESENT;
        end
      end
      S_PRESENT: begin
        if (ack) begin
          valid_d = 1'b0;
          state_d = S_GAP;
        end
      end
      S_GAP: begin
        valid_d = 1'b0;
        state_d = S_IDLE;
      end
      default: begin
        valid_d = 1'b0;
        state_d = S_IDLE;
      end
    endcase
  end

  // State, code and pending registers.
  always_ff @(posedge sys_clk or negedge resetl) begin
    if (!resetl) begin
      state_q <= S_IDLE;
      z_q     <= 3'd0;
      valid_q <= 1'b0;
      pend_q  <= 8'h00;
    end else begin
      state_q <= state_d;
      z_q     <= z_d;
      valid_q <= valid_d;
      pend_q  <= pend_d;
    end
  end

  assign z     = z_q;
  assign valid = valid_q;
  assign pend  = pend_q;

endmodule
